// File: rtl/axi_lite_cfg_slave.sv
// axi_lite_cfg_slave
//
// AXI4-Lite register responder for the digitRecog configuration bus. Register writes are
// decoded into weight/bias load strobes and layer/neuron selects for the neuron array. The
// block also holds the datapath soft reset, and latches the classified digit, raising intr
// until the host reads the result.
//
// Ports
//   s_axi_aclk, s_axi_aresetn        clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*                  AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*                     AXI4-Lite read address and data channels
//   weight_valid, bias_valid         one-cycle load strobes
//   cfg_data                         payload of the last WEIGHT/BIAS write
//   cfg_layer, cfg_neuron            current layer/neuron selects
//   weight_addr                      weight index presented alongside weight_valid
//   soft_reset                       active-high datapath soft reset
//   digit_valid, digit               result pulse from the output layer
//   intr                             result-ready interrupt
//
// Register map (decoded on addr[4:2])
//   0x00 WEIGHT (WO)  0x04 BIAS (WO)    0x08 RESULT (RO)  0x0C LAYER (RW)
//   0x10 NEURON (RW)  0x14 WADDR (RO)   0x18 STATUS (RO)  0x1C SOFTRST (RW)

module axi_lite_cfg_slave #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LAYER_W    = 8,
    parameter int unsigned NEURON_W   = 8,
    parameter int unsigned WADDR_W    = 10
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,

    input  logic [31:0]           s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic [31:0]           s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic                  weight_valid,
    output logic                  bias_valid,
    output logic [DATA_WIDTH-1:0] cfg_data,
    output logic [LAYER_W-1:0]    cfg_layer,
    output logic [NEURON_W-1:0]   cfg_neuron,
    output logic [WADDR_W-1:0]    weight_addr,
    output logic                  soft_reset,

    input  logic                  digit_valid,
    input  logic [DATA_WIDTH-1:0] digit,
    output logic                  intr
);

    typedef enum logic [2:0] {
        RegWeight  = 3'd0,
        RegBias    = 3'd1,
        RegResult  = 3'd2,
        RegLayer   = 3'd3,
        RegNeuron  = 3'd4,
        RegWaddr   = 3'd5,
        RegStatus  = 3'd6,
        RegSoftRst = 3'd7
    } reg_sel_e;

    // State
    logic                  aw_ready_q,   aw_ready_d;
    logic                  bvalid_q,     bvalid_d;
    logic                  ar_ready_q,   ar_ready_d;
    logic                  rvalid_q,     rvalid_d;
    logic [31:0]           rdata_q,      rdata_d;
    logic                  rd_result_q,  rd_result_d;
    logic                  weight_valid_q, weight_valid_d;
    logic                  bias_valid_q, bias_valid_d;
    logic [DATA_WIDTH-1:0] cfg_data_q,   cfg_data_d;
    logic [LAYER_W-1:0]    layer_q,      layer_d;
    logic [NEURON_W-1:0]   neuron_q,     neuron_d;
    logic [WADDR_W-1:0]    waddr_q,      waddr_d;
    logic                  soft_reset_q, soft_reset_d;
    logic                  intr_q,       intr_d;
    logic [DATA_WIDTH-1:0] digit_q,      digit_d;

    // Decode helpers
    logic                  wr_fire;
    logic                  rd_fire;
    reg_sel_e              wr_sel;
    reg_sel_e              rd_sel;
    logic [31:0]           wmask;
    logic [31:0]           rdata_mux;

    assign wr_fire = aw_ready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire = ar_ready_q & s_axi_arvalid;
    assign wr_sel  = reg_sel_e'(s_axi_awaddr[4:2]);
    assign rd_sel  = reg_sel_e'(s_axi_araddr[4:2]);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wmask[i*8 +: 8] = {8{s_axi_wstrb[i]}};
        end
    end

    // Read data selection, sampled on the AR handshake
    always_comb begin
        rdata_mux = '0;
        unique case (rd_sel)
            RegResult:  rdata_mux[DATA_WIDTH-1:0] = digit_q;
            RegLayer:   rdata_mux[LAYER_W-1:0]    = layer_q;
            RegNeuron:  rdata_mux[NEURON_W-1:0]   = neuron_q;
            RegWaddr:   rdata_mux[WADDR_W-1:0]    = waddr_q;
            RegStatus:  rdata_mux[1:0]            = {soft_reset_q, intr_q};
            RegSoftRst: rdata_mux[0]              = soft_reset_q;
            default:    rdata_mux = '0;
        endcase
    end

    always_comb begin
        // Write channel: awready/wready only after both halves are present, never while a
        // response is outstanding.
        aw_ready_d = ~aw_ready_q & ~bvalid_q & s_axi_awvalid & s_axi_wvalid;

        bvalid_d = bvalid_q;
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end

        weight_valid_d = wr_fire && (wr_sel == RegWeight);
        bias_valid_d   = wr_fire && (wr_sel == RegBias);

        cfg_data_d   = cfg_data_q;
        layer_d      = layer_q;
        neuron_d     = neuron_q;
        soft_reset_d = soft_reset_q;

        // The counter advances the cycle after the strobe so weight_addr shows the index
        // belonging to the current weight_valid.
        waddr_d = waddr_q;
        if (weight_valid_q) begin
            waddr_d = waddr_q + WADDR_W'(1);
        end

        if (wr_fire) begin
            unique case (wr_sel)
                RegWeight, RegBias: begin
                    cfg_data_d = s_axi_wdata[DATA_WIDTH-1:0];
                end
                RegLayer: begin
                    layer_d = (layer_q & ~wmask[LAYER_W-1:0])
                            | (s_axi_wdata[LAYER_W-1:0] & wmask[LAYER_W-1:0]);
                    waddr_d = '0;
                end
                RegNeuron: begin
                    neuron_d = (neuron_q & ~wmask[NEURON_W-1:0])
                             | (s_axi_wdata[NEURON_W-1:0] & wmask[NEURON_W-1:0]);
                    waddr_d  = '0;
                end
                RegSoftRst: begin
                    if (s_axi_wstrb[0]) begin
                        soft_reset_d = s_axi_wdata[0];
                    end
                end
                default: ;
            endcase
        end

        // Read channel
        ar_ready_d = ~ar_ready_q & ~rvalid_q & s_axi_arvalid;

        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rd_result_d = rd_result_q;
        if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (rd_fire) begin
            rvalid_d    = 1'b1;
            rdata_d     = rdata_mux;
            rd_result_d = (rd_sel == RegResult);
        end

        // Result / interrupt: a new digit beats a simultaneous RESULT-read clear, and soft
        // reset masks everything.
        digit_d = digit_q;
        intr_d  = intr_q;
        if (rvalid_q && s_axi_rready && rd_result_q) begin
            intr_d = 1'b0;
        end
        if (digit_valid && !soft_reset_q) begin
            intr_d  = 1'b1;
            digit_d = digit;
        end
        if (soft_reset_q) begin
            intr_d = 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_ready_q     <= 1'b0;
            bvalid_q       <= 1'b0;
            ar_ready_q     <= 1'b0;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            rd_result_q    <= 1'b0;
            weight_valid_q <= 1'b0;
            bias_valid_q   <= 1'b0;
            cfg_data_q     <= '0;
            layer_q        <= '0;
            neuron_q       <= '0;
            waddr_q        <= '0;
            soft_reset_q   <= 1'b1;
            intr_q         <= 1'b0;
            digit_q        <= '0;
        end else begin
            aw_ready_q     <= aw_ready_d;
            bvalid_q       <= bvalid_d;
            ar_ready_q     <= ar_ready_d;
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
            rd_result_q    <= rd_result_d;
            weight_valid_q <= weight_valid_d;
            bias_valid_q   <= bias_valid_d;
            cfg_data_q     <= cfg_data_d;
            layer_q        <= layer_d;
            neuron_q       <= neuron_d;
            waddr_q        <= waddr_d;
            soft_reset_q   <= soft_reset_d;
            intr_q         <= intr_d;
            digit_q        <= digit_d;
        end
    end

    assign s_axi_awready = aw_ready_q;
    assign s_axi_wready  = aw_ready_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = ar_ready_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;

    assign weight_valid = weight_valid_q;
    assign bias_valid   = bias_valid_q;
    assign cfg_data     = cfg_data_q;
    assign cfg_layer    = layer_q;
    assign cfg_neuron   = neuron_q;
    assign weight_addr  = waddr_q;
    assign soft_reset   = soft_reset_q;
    assign intr         = intr_q;

    // Protection bits and undecoded address/data bits are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                             s_axi_wdata, s_axi_wstrb};

endmodule

// File: tb/tb_axi_lite_cfg_slave.sv
module tb_axi_lite_cfg_slave;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        weight_valid, bias_valid, soft_reset, digit_valid, intr;
    logic [15:0] cfg_data, digit;
    logic [7:0]  cfg_layer, cfg_neuron;
    logic [9:0]  weight_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (register-map level view)
    logic [31:0] m_layer, m_neuron, m_waddr, m_digit;
    logic        m_soft, m_intr;

    always #5 clk = ~clk;

    axi_lite_cfg_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .weight_valid  (weight_valid),
        .bias_valid    (bias_valid),
        .cfg_data      (cfg_data),
        .cfg_layer     (cfg_layer),
        .cfg_neuron    (cfg_neuron),
        .weight_addr   (weight_addr),
        .soft_reset    (soft_reset),
        .digit_valid   (digit_valid),
        .digit         (digit),
        .intr          (intr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_layer = 0; m_neuron = 0; m_waddr = 0; m_digit = 0; m_soft = 1'b1; m_intr = 1'b0;
    endtask

    function automatic logic [31:0] merge8(input logic [31:0] old, input logic [31:0] data,
                                           input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r & 32'hFF;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        case (addr[4:2])
            3'd2:    return m_digit;
            3'd3:    return m_layer;
            3'd4:    return m_neuron;
            3'd5:    return m_waddr;
            3'd6:    return {30'd0, m_soft, m_intr};
            3'd7:    return {31'd0, m_soft};
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_awready(output bit ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (awready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("aw_accept_timeout", 32'd0, 32'd1);
            ok = 1'b0;
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        bit ok;
        logic [2:0] sel;
        sel = addr[4:2];
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_awready(ok);
        if (!ok) begin
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check("wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_set", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, 32'd0);
        check("awready_drop", {31'd0, awready}, 32'd0);
        check("weight_valid", {31'd0, weight_valid}, {31'd0, sel == 3'd0});
        check("bias_valid", {31'd0, bias_valid}, {31'd0, sel == 3'd1});
        if (sel == 3'd0 || sel == 3'd1) begin
            check("cfg_data", {16'd0, cfg_data}, data & 32'hFFFF);
            check("strobe_waddr", {22'd0, weight_addr}, m_waddr);
            check("strobe_layer", {24'd0, cfg_layer}, m_layer);
            check("strobe_neuron", {24'd0, cfg_neuron}, m_neuron);
        end
        case (sel)
            3'd0: m_waddr = (m_waddr + 1) & 32'h3FF;
            3'd3: begin m_layer  = merge8(m_layer, data, strb);  m_waddr = 0; end
            3'd4: begin m_neuron = merge8(m_neuron, data, strb); m_waddr = 0; end
            3'd7: if (strb[0]) m_soft = data[0];
            default: ;
        endcase
        if (m_soft) m_intr = 1'b0;
        @(negedge clk);
        check("bvalid_clear", {31'd0, bvalid}, 32'd0);
        check("strobe_pulse", {30'd0, weight_valid, bias_valid}, 32'd0);
        check("waddr_after", {22'd0, weight_addr}, m_waddr);
        check("layer", {24'd0, cfg_layer}, m_layer);
        check("neuron", {24'd0, cfg_neuron}, m_neuron);
        check("soft_reset", {31'd0, soft_reset}, {31'd0, m_soft});
        check("intr_after_wr", {31'd0, intr}, {31'd0, m_intr});
    endtask

    // A digit pulse may be made coincident with the R handshake.
    task automatic axi_read(input logic [31:0] addr, input bit coincide, input logic [15:0] cd);
        logic [31:0] exp;
        int n = 0;
        exp = model_read(addr);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        while (arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("ar_accept_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_set", {31'd0, rvalid}, 32'd1);
        check("rdata", rdata, exp);
        check("rresp", {30'd0, rresp}, 32'd0);
        @(negedge clk);
        check("rdata_stable", rdata, exp);
        check("rvalid_hold", {31'd0, rvalid}, 32'd1);
        rready = 1'b1;
        if (coincide) begin
            digit_valid = 1'b1; digit = cd;
        end
        @(negedge clk);
        rready = 1'b0; digit_valid = 1'b0;
        check("rvalid_clear", {31'd0, rvalid}, 32'd0);
        if (addr[4:2] == 3'd2) m_intr = 1'b0;
        if (coincide && !m_soft) begin
            m_intr = 1'b1; m_digit = {16'd0, cd};
        end
        check("intr_after_rd", {31'd0, intr}, {31'd0, m_intr});
    endtask

    task automatic pulse_digit(input logic [15:0] d);
        @(negedge clk);
        digit_valid = 1'b1; digit = d;
        @(negedge clk);
        digit_valid = 1'b0;
        if (!m_soft) begin
            m_digit = {16'd0, d}; m_intr = 1'b1;
        end
        check("intr_after_digit", {31'd0, intr}, {31'd0, m_intr});
    endtask

    initial begin
        bit ok;
        aresetn = 1'b0;
        awaddr = 0; wdata = 0; wstrb = 0; awvalid = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0; awprot = 0; arprot = 0;
        digit_valid = 0; digit = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_soft_reset", {31'd0, soft_reset}, 32'd1);
        check("rst_handshake", {26'd0, awready, wready, bvalid, arready, rvalid, intr}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_cfg", {cfg_data, cfg_layer, cfg_neuron}, 32'd0);
        check("rst_waddr", {22'd0, weight_addr}, 32'd0);
        aresetn = 1'b1;

        // Status, soft-reset release, digit ignored while in soft reset
        axi_read(32'h18, 1'b0, 16'd0);
        pulse_digit(16'd9);
        axi_write(32'h1C, 32'h0, 4'hF);
        axi_read(32'h18, 1'b0, 16'd0);

        // Selects and sequential weight loads
        axi_write(32'h0C, 32'h2, 4'hF);
        axi_write(32'h10, 32'h5, 4'hF);
        axi_write(32'h00, 32'h11, 4'hF);
        axi_write(32'h00, 32'h22, 4'h0);
        axi_write(32'h00, 32'h33, 4'hF);
        axi_read(32'h14, 1'b0, 16'd0);
        axi_write(32'h10, 32'h6, 4'hF);
        axi_write(32'h04, 32'h7F, 4'hF);
        axi_read(32'h14, 1'b0, 16'd0);

        // Result / interrupt, including set-beats-clear
        pulse_digit(16'd7);
        axi_read(32'h08, 1'b0, 16'd0);
        pulse_digit(16'd3);
        axi_read(32'h08, 1'b1, 16'd4);
        axi_read(32'h08, 1'b0, 16'd0);

        // B backpressure: second write must wait for the B handshake
        awaddr = 32'h0C; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0;
        wait_awready(ok);
        @(negedge clk);
        m_layer = 32'h3; m_waddr = 0;
        awaddr = 32'h10; wdata = 32'h9;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);
            check("bp_no_accept", {30'd0, awready, wready}, 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bp_bvalid_clear", {31'd0, bvalid}, 32'd0);
        check("bp_first_layer", {24'd0, cfg_layer}, 32'h3);
        axi_write(32'h10, 32'h9, 4'hF);

        // Counter wrap at 2^10
        for (int i = 0; i < 1026; i++) axi_write(32'h00, i, 4'hF);
        axi_read(32'h14, 1'b0, 16'd0);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int unsigned r;
            logic [31:0] a, d;
            logic [3:0]  s;
            r = $urandom_range(0, 9);
            a = ($urandom & 32'hFFFF_FFE0) | ($urandom_range(0, 7) << 2);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (r <= 3) begin
                if (a[4:2] == 3'd7) d = ($urandom_range(0, 5) == 0) ? 32'h1 : 32'h0;
                axi_write(a, d, s);
            end else if (r <= 6) begin
                axi_read(a, 1'b0, 16'd0);
            end else if (r <= 8) begin
                pulse_digit(16'($urandom));
            end else begin
                axi_read(32'h08, 1'b1, 16'($urandom));
            end
        end

        // Async reset while a read response is pending
        axi_write(32'h1C, 32'h0, 4'hF);
        @(negedge clk);
        araddr = 32'h14; arvalid = 1'b1; rready = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (arready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        arvalid = 1'b0;
        check("ar_rvalid_before_rst", {31'd0, rvalid}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        model_reset();
        check("async_rvalid", {31'd0, rvalid}, 32'd0);
        check("async_soft_reset", {31'd0, soft_reset}, 32'd1);
        check("async_rdata", rdata, 32'd0);
        check("async_cfg", {cfg_layer, cfg_neuron, 6'd0, weight_addr}, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        axi_read(32'h18, 1'b0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
